move_command_transmitter: RTL
=============================

# move_command_transmitter

Serialises the 12-bit rover move command (angle [11:7], distance [6:0]) produced by the orientation/path calculator and transmits it to the rover as an IR pulse-width-coded frame. Each frame is a start mark, 12 data bits LSB first and an inter-frame gap, repeated REPEATS times. The block sits between the path calculator's `move_command` output and the IR LED driver pin. It reports busy/done so the calculator can sequence orientation and move steps.

## Interface
- CYCLES_PER_UNIT, 16200: clock cycles per protocol time unit U (600 µs at 27 MHz).
- CARRIER_DIV, 675: clock cycles per carrier period (40 kHz at 27 MHz).
- FRAME_UNITS, 75: total frame length in units, gap included (45 ms).
- REPEATS, 3: frames sent per `send`.
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- send  in  1  start request; sampled on the rising edge of `clock`.
- command  in  12  move command; angle [11:7], distance [6:0].
- ir_out  out  1  LED drive: carrier during marks, 0 during spaces and gap.
- busy  out  1  high from the cycle after an accepted `send` until `done`.
- done  out  1  one-cycle pulse after the last frame's gap ends.

## Operation
- Reset values: `ir_out`=0, `busy`=0, `done`=0, state IDLE, all counters 0, latched command 0.
- IDLE: when `send`=1, latch `command`, clear the repeat counter and go to START.
  - `send` while busy is ignored.
  - `command` changes while busy have no effect.
- START: mark for 4 U, then space for 1 U, then go to BIT.
- BIT: bit index i runs 0..11, taken from the latched command (distance bits first, then angle).
  - Mark for 2 U if the bit is 1, 1 U if it is 0.
  - Then space for 1 U.
  - After i=11 go to GAP.
- GAP: `ir_out`=0 until FRAME_UNITS units have elapsed since the frame began (START entry).
  - Frame active length = 29 + popcount(command) units, so 29..41 U.
  - Gap length = FRAME_UNITS − active length.
  - If fewer repeats than REPEATS have been sent, go to START; otherwise go to IDLE and pulse `done`.
- Mark output: `ir_out` = carrier, high for the first CARRIER_DIV/2 cycles of each carrier period. The carrier counter restarts at 0 at the start of every mark.
- Unit timing: a unit counter counts 0..CYCLES_PER_UNIT−1, and a frame unit counter counts 0..FRAME_UNITS−1.
- Counter widths use $clog2 of their parameters.
- Reset asserted mid-frame: `ir_out` drops to 0 asynchronously and no `done` pulse is produced.

## Timing
- Accepted `send` at edge k:
  - `busy`=1 and the first mark cycle (`ir_out`=1) are visible after edge k.
  - Latency from `send` to first mark is 1 cycle.
- Each mark and space lasts exactly n·CYCLES_PER_UNIT cycles.
- Each frame lasts exactly FRAME_UNITS·CYCLES_PER_UNIT cycles.
- `done` rises exactly REPEATS·FRAME_UNITS·CYCLES_PER_UNIT cycles after `busy` rises.
  - In that same cycle `busy` falls.
- `send`=1 in the `done` cycle is accepted: back-to-back transmissions leave zero idle cycles.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- IR_CARRIER_EN defined: marks are modulated with the CARRIER_DIV carrier as above.
- IR_CARRIER_EN undefined:
  - `ir_out` is the raw envelope, 1 for the whole mark.
  - The carrier counter is not instantiated.
  - Used for the wired debug link and the logic analyser.
- All timing other than modulation is identical in both builds.

## Structure
- Shared package `rover_pkg` holds:
  - the command field constants: ANGLE_MSB=11, ANGLE_LSB=7, DIST_MSB=6, DIST_LSB=0, CMD_W=12;
  - the protocol mark lengths: START_MARK_U=4, ONE_MARK_U=2, ZERO_MARK_U=1, SPACE_U=1;
  - the state encoding type (IDLE, START, BIT, GAP).
- Sub-module `ir_carrier_gen` (parameter CARRIER_DIV; ports `clock`, `reset_n`, `restart`, `carrier`). It is instantiated only under IR_CARRIER_EN.

## Test plan
Benches use CYCLES_PER_UNIT=4, CARRIER_DIV=2, FRAME_UNITS=75, REPEATS=1 unless noted.
- Command 12'h000 with `send` pulse -> envelope is 16 cycles mark, 4 space, then twelve (4 mark, 4 space) pairs. `done` pulses 300 cycles after `busy` rises.
- Command 12'hFFF -> every bit mark is 8 cycles, the gap is 136 cycles, and frame length stays 300 cycles.
- Command 12'h105 -> marks decode to bits 1,0,1,0,0,0,0,0,1,0,0,0 (LSB first); bits 0, 2 and 8 have 8-cycle marks.
- REPEATS=3 with `send` held high throughout -> exactly three identical frames and one `done` at cycle 900. A re-send starts in the `done` cycle.
- `reset_n` driven low at cycle 50 of a frame -> `ir_out`=0 and `busy`=0 immediately, no `done`. The next `send` produces a full frame.
- Build with and without IR_CARRIER_EN, command 12'h0A5 -> with the macro, `ir_out` toggles every cycle during marks; without it, `ir_out` is solid 1 during marks. Envelopes match in both builds.

Source files
------------

// File: rtl/rover_pkg.sv
// Shared rover definitions: move command field layout, IR protocol mark
// lengths and the transmitter state encoding.
package rover_pkg;

    localparam int ANGLE_MSB = 32'd11;
    localparam int ANGLE_LSB = 32'd7;
    localparam int DIST_MSB  = 32'd6;
    localparam int DIST_LSB  = 32'd0;
    localparam int CMD_W     = 32'd12;

    localparam logic [2:0] START_MARK_U = 3'd4;
    localparam logic [2:0] ONE_MARK_U   = 3'd2;
    localparam logic [2:0] ZERO_MARK_U  = 3'd1;
    localparam logic [2:0] SPACE_U      = 3'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BIT   = 2'd2,
        GAP   = 2'd3
    } tx_state_e;

    // Mark length in units for one data bit.
    function automatic logic [2:0] bit_mark_units(input logic bit_val);
        return bit_val ? ONE_MARK_U : ZERO_MARK_U;
    endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// IR carrier phase generator. `carrier` is the level for the NEXT cycle so the
// parent can register it straight into its output flop; `restart` forces phase 0.
module ir_carrier_gen #(
    parameter int CARRIER_DIV = 675
) (
    input  logic clock,
    input  logic reset_n,
    input  logic restart,
    output logic carrier
);

    localparam int CW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
    localparam logic [CW-1:0] PHASE_MAX = CW'(CARRIER_DIV - 1);
    localparam logic [CW-1:0] HIGH_LEN  = CW'(CARRIER_DIV / 2);

    logic [CW-1:0] phase_r;
    logic [CW-1:0] phase_s;

    // Next carrier phase: wraps each period, forced to 0 at a mark start.
    always_comb begin
        phase_s = phase_r;
        if (restart) begin
            phase_s = '0;
        end else if (phase_r == PHASE_MAX) begin
            phase_s = '0;
        end else begin
            phase_s = phase_r + CW'(1'b1);
        end
    end

    // Carrier phase register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_r <= '0;
        end else begin
            phase_r <= phase_s;
        end
    end

    assign carrier = (phase_s < HIGH_LEN);

endmodule

// File: rtl/move_command_transmitter.sv
// Sends the 12-bit rover move command as a pulse-width-coded IR frame, REPEATS
// times. Define IR_CARRIER_EN to modulate marks; otherwise ir_out is the envelope.
module move_command_transmitter
    import rover_pkg::*;
#(
    parameter int CYCLES_PER_UNIT = 16200,
    parameter int CARRIER_DIV     = 675,
    parameter int FRAME_UNITS     = 75,
    parameter int REPEATS         = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             send,
    input  logic [CMD_W-1:0] command,
    output logic             ir_out,
    output logic             busy,
    output logic             done
);

    localparam int UW = (CYCLES_PER_UNIT > 1) ? $clog2(CYCLES_PER_UNIT) : 1;
    localparam int FW = (FRAME_UNITS > 1) ? $clog2(FRAME_UNITS) : 1;
    localparam int RW = (REPEATS > 1) ? $clog2(REPEATS) : 1;
    localparam logic [UW-1:0] UNIT_MAX  = UW'(CYCLES_PER_UNIT - 1);
    localparam logic [FW-1:0] FRAME_MAX = FW'(FRAME_UNITS - 1);
    localparam logic [RW-1:0] REP_MAX   = RW'(REPEATS - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(CMD_W - 1);

    tx_state_e        state_r, state_s;
    logic [CMD_W-1:0] cmd_r, cmd_s;
    logic [RW-1:0]    rep_r, rep_s;
    logic [UW-1:0]    unit_r, unit_s;
    logic [FW-1:0]    frame_unit_r, frame_unit_s;
    logic [2:0]       seg_left_r, seg_left_s;
    logic             in_mark_r, in_mark_s;
    logic [3:0]       bit_idx_r, bit_idx_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             ir_out_r, ir_s;
    logic             mark_start_s;
    logic             unit_end_s;
    logic             seg_end_s;
    logic             frame_end_s;

    // Next-state logic: segments are counted in units of remaining length.
    always_comb begin
        state_s      = state_r;
        cmd_s        = cmd_r;
        rep_s        = rep_r;
        unit_s       = unit_r;
        frame_unit_s = frame_unit_r;
        seg_left_s   = seg_left_r;
        in_mark_s    = in_mark_r;
        bit_idx_s    = bit_idx_r;
        busy_s       = busy_r;
        done_s       = 1'b0;
        mark_start_s = 1'b0;
        unit_end_s   = (unit_r == UNIT_MAX);
        seg_end_s    = unit_end_s && (seg_left_r == 3'd0);
        frame_end_s  = unit_end_s && (frame_unit_r == FRAME_MAX);

        if (state_r == IDLE) begin
            if (send) begin
                cmd_s        = command;
                rep_s        = '0;
                unit_s       = '0;
                frame_unit_s = '0;
                bit_idx_s    = 4'd0;
                seg_left_s   = START_MARK_U - 3'd1;
                in_mark_s    = 1'b1;
                mark_start_s = 1'b1;
                busy_s       = 1'b1;
                state_s      = START;
            end else begin
                busy_s = 1'b0;
            end
        end else begin
            if (unit_end_s) begin
                unit_s       = '0;
                frame_unit_s = (frame_unit_r == FRAME_MAX) ? '0 : frame_unit_r + FW'(1'b1);
                seg_left_s   = (seg_left_r != 3'd0) ? seg_left_r - 3'd1 : seg_left_r;
            end else begin
                unit_s = unit_r + UW'(1'b1);
            end

            case (state_r)
                START: begin
                    if (seg_end_s && in_mark_r) begin
                        in_mark_s  = 1'b0;
                        seg_left_s = SPACE_U - 3'd1;
                    end else if (seg_end_s) begin
                        bit_idx_s    = 4'd0;
                        in_mark_s    = 1'b1;
                        mark_start_s = 1'b1;
                        seg_left_s   = bit_mark_units(cmd_r[0]) - 3'd1;
                        state_s      = BIT;
                    end else begin
                        state_s = START;
                    end
                end
                BIT: begin
                    if (seg_end_s && in_mark_r) begin
                        in_mark_s  = 1'b0;
                        seg_left_s = SPACE_U - 3'd1;
                    end else if (seg_end_s && (bit_idx_r == LAST_BIT)) begin
                        state_s = GAP;
                    end else if (seg_end_s) begin
                        bit_idx_s    = bit_idx_r + 4'd1;
                        in_mark_s    = 1'b1;
                        mark_start_s = 1'b1;
                        seg_left_s   = bit_mark_units(cmd_r[bit_idx_r + 4'd1]) - 3'd1;
                    end else begin
                        state_s = BIT;
                    end
                end
                GAP: begin
                    in_mark_s = 1'b0;
                    if (frame_end_s && (rep_r == REP_MAX)) begin
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        state_s = IDLE;
                    end else if (frame_end_s) begin
                        rep_s        = rep_r + RW'(1'b1);
                        bit_idx_s    = 4'd0;
                        in_mark_s    = 1'b1;
                        mark_start_s = 1'b1;
                        seg_left_s   = START_MARK_U - 3'd1;
                        state_s      = START;
                    end else begin
                        state_s = GAP;
                    end
                end
                default: begin
                    in_mark_s = 1'b0;
                    busy_s    = 1'b0;
                    state_s   = IDLE;
                end
            endcase
        end
    end

`ifdef IR_CARRIER_EN
    logic carrier_s;

    ir_carrier_gen #(
        .CARRIER_DIV(CARRIER_DIV)
    ) u_carrier (
        .clock   (clock),
        .reset_n (reset_n),
        .restart (mark_start_s),
        .carrier (carrier_s)
    );

    assign ir_s = in_mark_s & carrier_s;
`else
    assign ir_s = in_mark_s;
`endif

    // State, counters and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            cmd_r        <= '0;
            rep_r        <= '0;
            unit_r       <= '0;
            frame_unit_r <= '0;
            seg_left_r   <= 3'd0;
            in_mark_r    <= 1'b0;
            bit_idx_r    <= 4'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            ir_out_r     <= 1'b0;
        end else begin
            state_r      <= state_s;
            cmd_r        <= cmd_s;
            rep_r        <= rep_s;
            unit_r       <= unit_s;
            frame_unit_r <= frame_unit_s;
            seg_left_r   <= seg_left_s;
            in_mark_r    <= in_mark_s;
            bit_idx_r    <= bit_idx_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            ir_out_r     <= ir_s;
        end
    end

    assign ir_out = ir_out_r;
    assign busy   = busy_r;
    assign done   = done_r;

endmodule
